// File: rtl/reg_file.sv
`timescale 1ns/1ps
// reg_file -- architectural general-purpose register file for the single-cycle CPU.
//
// Two combinational read ports, one synchronous write port, register 0 hardwired
// to zero, and a counter of committed writes since reset.
//
// Ports:
//   clk       in   system clock, all state updates on the rising edge
//   rst       in   asynchronous active-high reset (clears registers and wr_count)
//   we        in   write enable for the current cycle
//   wa        in   write address
//   wd        in   write data (from the write-back select)
//   ra1/ra2   in   read addresses (rs / rt)
//   rd1/rd2   out  read data
//   wr_count  out  committed writes since reset, wraps modulo 2**32
//
// Optional feature, macro REGFILE_DEBUG_PORT_EN:
//   dbg_addr  in   debug read address
//   dbg_data  out  stored contents of reg[dbg_addr], never bypassed; 0 for address 0
//
// Parameter BYPASS: 1 = a read whose address matches a pending write returns wd;
// 0 = reads always return stored contents.

module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
`ifdef REGFILE_DEBUG_PORT_EN
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
`endif
  output logic [31:0]           wr_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [31:0]           wr_count_q;
  logic [31:0]           wr_count_d;
  logic                  commit;
  logic                  hit1;
  logic                  hit2;

  // Writes to register 0 are dropped entirely, including the count.
  assign commit = we && (wa != '0);

  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (commit) begin
      regs_d[wa] = wd;
      wr_count_d = wr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  // The write-through path ignores rst: a matching read may show wd during
  // reset, but the write itself never commits while rst is high.
  assign hit1 = (BYPASS != 0) && we && (ra1 == wa);
  assign hit2 = (BYPASS != 0) && we && (ra2 == wa);

  always_comb begin
    rd1 = regs_q[ra1];
    if (ra1 == '0) begin
      rd1 = '0;
    end else if (hit1) begin
      rd1 = wd;
    end
  end

  always_comb begin
    rd2 = regs_q[ra2];
    if (ra2 == '0) begin
      rd2 = '0;
    end else if (hit2) begin
      rd2 = wd;
    end
  end

  assign wr_count = wr_count_q;

`ifdef REGFILE_DEBUG_PORT_EN
  always_comb begin
    dbg_data = regs_q[dbg_addr];
    if (dbg_addr == '0) begin
      dbg_data = '0;
    end
  end
`endif

endmodule
